alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// out/ovf are registered and change only on the edge that enters DONE.
module alu_seq #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         func,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               ovf
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_MUL = 2'b10;

    typedef struct packed {
        logic [1:0]       func;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    logic [1:0]         state;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = {1'b0, a} - {1'b0, b};

    // acc is {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_q.a : {WIDTH{1'b0}})};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, op_q.b};
        div_diff  = div_shift[WIDTH-1:0] - op_q.b;
        acc_nxt   = acc;
        if (op_q.func == F_MUL)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else
            acc_nxt = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            cnt   <= '0;
            acc   <= '0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= {func, a, b};
                        cnt  <= CW'(WIDTH - 1);
                        case (func)
                            F_ADD: begin
                                out   <= {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                                ovf   <= add_sum[WIDTH];
                                state <= S_DONE;
                            end
                            F_SUB: begin
                                out   <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                                ovf   <= sub_diff[WIDTH];
                                state <= S_DONE;
                            end
                            F_MUL: begin
                                acc   <= {{WIDTH{1'b0}}, b};
                                state <= S_CALC;
                            end
                            default: begin
                                if (b == '0) begin
                                    out   <= {a, {WIDTH{1'b1}}};
                                    ovf   <= 1'b1;
                                    state <= S_DONE;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, a};
                                    state <= S_CALC;
                                end
                            end
                        endcase
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        out   <= acc_nxt;
                        ovf   <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule
